edge_filter_3x3: RTL and testbench
==================================

EDGE_FILTER_3X3 -- requirements
Module: edge_filter_3x3

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning pixel bit width.
REQ-002 The block SHALL have parameter MAX_W, default 1024, meaning maximum line width in pixels, which sets line-buffer depth.
REQ-003 The block SHALL have these ports:
  clk  in  1  clock, all logic rising-edge
  rst  in  1  asynchronous, active-high reset
  s_valid  in  1  input pixel valid
  s_ready  out  1  input pixel accepted when s_valid&&s_ready
  s_data  in  DATA_W  input grayscale pixel, raster order
  s_sof  in  1  marks first pixel of a frame
  cfg_width  in  clog2(MAX_W+1)  active line width
  cfg_mode  in  2  00 Sobel, 01 Prewitt, 10 Sobel-threshold, 11 passthrough
  cfg_thresh  in  DATA_W  threshold for mode 10
  m_valid  out  1  output pixel valid
  m_ready  in  1  downstream ready
  m_data  out  DATA_W  filtered pixel
  m_sof  out  1  first output pixel of a frame
  m_eol  out  1  last output pixel of a line

Function
REQ-004 Pipeline enable SHALL be en = !m_valid || m_ready; s_ready SHALL equal en; no state SHALL change while en=0.
REQ-005 Each accepted pixel SHALL update two line buffers (MAX_W deep), a 3x3 window shifted left by one column, and col/row counters.
REQ-006 Col SHALL wrap from cfg_width-1 to 0 with row+1; row SHALL saturate at 2.
REQ-007 An accepted pixel with s_sof=1 SHALL be treated as col=0,row=0; counters SHALL restart; the window SHALL be invalidated; outputs already in the pipeline SHALL still drain.
REQ-008 Pixels accepted after reset before the first s_sof SHALL be consumed and produce no output.
REQ-009 cfg_width, cfg_mode and cfg_thresh SHALL be latched on s_sof acceptance; mid-frame changes SHALL be ignored; latched width below 3 SHALL be clamped to 3.
REQ-010 Only pixels accepted at row>=2 and col>=2 SHALL produce an output; output frame is (W-2)x(H-2), centred on (row-1,col-1).
REQ-011 Output SHALL appear on m_valid exactly 2 enabled cycles after the producing pixel's acceptance: stage 1 registers gx/gy, stage 2 registers m_data.
REQ-012 gx, gy SHALL be signed, DATA_W+4 bits. Sobel weights are 1,2,1 and Prewitt weights are 1,1,1. gx = left column − right column; gy = top row − bottom row.
REQ-013 Magnitude SHALL be |gx|+|gy|, saturated to 2^DATA_W−1.
REQ-014 Mode 10 SHALL output 2^DATA_W−1 when the Sobel magnitude >= cfg_thresh, else 0. Mode 11 SHALL output the window centre pixel unchanged.
REQ-015 m_sof SHALL be 1 with the first output after each s_sof; m_eol SHALL be 1 with the output produced by col=cfg_width-1.
REQ-016 m_valid SHALL stay asserted with m_data/m_sof/m_eol stable until m_ready=1.

Reset
REQ-017 Reset SHALL clear m_valid, m_data, m_sof, m_eol, pipeline valids, counters, latched config (width=3, mode=00, thresh=0), and the "frame started" flag.
REQ-018 Line-buffer and window contents SHALL NOT require reset; outputs SHALL NOT depend on them before being rewritten.
REQ-019 Reset asserted mid-frame SHALL drop all in-flight outputs; s_ready SHALL be 1 during and after reset.

Verification
REQ-020 Verification SHALL cover: DATA_W=8, width 8, 4 rows, constant 100 in mode 00, m_ready=1 -> 12 outputs, all 0; m_sof on first output; m_eol on every 6th.
REQ-021 Verification SHALL cover: vertical edge, columns 0-3 = 0 and columns 4-7 = 255, mode 00 -> interior outputs across the edge saturate to 255; others 0; first output 2 cycles after the 19th accepted pixel.
REQ-022 Verification SHALL cover: the same edge image in mode 01 with cfg_thresh unused -> edge outputs = 255 (3*255 saturated); mode 10 with thresh=200 -> outputs only 0 or 255, 255 exactly where the Sobel magnitude is >= 200.
REQ-023 Verification SHALL cover: random m_ready backpressure (50%) in mode 11 -> output sequence equals the interior pixels in raster order with no loss or duplication; m_data stable while stalled.
REQ-024 Verification SHALL cover: s_sof reasserted at row 1 col 3 with cfg_width changed from 8 to 5 -> no output mixes old-frame pixels; the new frame outputs 3 per line.
REQ-025 Verification SHALL cover: rst pulsed while m_valid=1 and m_ready=0 -> m_valid=0 on the next edge; no output until s_sof plus 2 rows and 2 columns.

Source files
------------

// File: rtl/edge_filter_3x3.sv
// 3x3 Sobel/Prewitt edge filter on a raster pixel stream, with two line buffers,
// a two-stage gradient/magnitude pipeline and ready/valid flow control on both sides.
module edge_filter_3x3 #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 1024,
  localparam int CW    = $clog2(MAX_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic [CW-1:0]     cfg_width,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_thresh,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol
);

  localparam int GW = DATA_W + 4;
  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef logic [DATA_W-1:0] pix_t;
  typedef enum logic [1:0] {
    MODE_SOBEL   = 2'b00,
    MODE_PREWITT = 2'b01,
    MODE_THRESH  = 2'b10,
    MODE_PASS    = 2'b11
  } mode_e;

  logic en;
  logic accept;
  assign en      = !m_valid || m_ready;
  assign s_ready = en;
  assign accept  = s_valid && en;

  // Position and frame configuration
  logic [CW-1:0] col, width_q;
  logic [1:0]    row;
  mode_e         mode_q;
  pix_t          thresh_q;
  logic          started;
  logic          sof_pend;

  // A start-of-frame pixel sees col=0,row=0 and the freshly presented config
  logic [CW-1:0] col_eff, width_eff;
  logic [1:0]    row_eff;
  mode_e         mode_eff;
  pix_t          thresh_eff;
  logic          last_col;
  logic          produce;

  always_comb begin
    col_eff    = col;
    row_eff    = row;
    width_eff  = width_q;
    mode_eff   = mode_q;
    thresh_eff = thresh_q;
    if (s_sof) begin
      col_eff    = '0;
      row_eff    = '0;
      mode_eff   = mode_e'(cfg_mode);
      thresh_eff = cfg_thresh;
      if (cfg_width < CW'(3))
        width_eff = CW'(3);
      else if (cfg_width > CW'(MAX_W))
        width_eff = CW'(MAX_W);
      else
        width_eff = cfg_width;
    end
    last_col = (col_eff == width_eff - CW'(1));
    produce  = (started || s_sof) && (row_eff == 2'd2) && (col_eff >= CW'(2));
  end

  // Line buffers and window: data only, never reset
  pix_t lb0 [MAX_W];
  pix_t lb1 [MAX_W];
  pix_t win [3][3];
  logic [AW-1:0] lb_idx;
  pix_t up1, up2;

  assign lb_idx = col_eff[AW-1:0];
  assign up1    = lb0[lb_idx];
  assign up2    = lb1[lb_idx];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[lb_idx] <= s_data;
      lb1[lb_idx] <= up1;
      for (int unsigned r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= up2;
      win[1][2] <= up1;
      win[2][2] <= s_data;
    end
  end

  function automatic logic signed [GW-1:0] ext(input pix_t p);
    return $signed({4'b0000, p});
  endfunction

  function automatic logic signed [GW-1:0] wsum(input pix_t a, input pix_t b,
                                                input pix_t c, input logic prew);
    logic signed [GW-1:0] mid;
    mid = prew ? ext(b) : (ext(b) <<< 1);
    return ext(a) + mid + ext(c);
  endfunction

  // Stage registers
  logic                 s0_valid, s0_sof, s0_eol;
  mode_e                s0_mode;
  pix_t                 s0_thresh;
  logic                 s1_valid, s1_sof, s1_eol;
  mode_e                s1_mode;
  pix_t                 s1_thresh, s1_center;
  logic signed [GW-1:0] s1_gx, s1_gy;

  logic                 prew;
  logic signed [GW-1:0] gx_c, gy_c;

  always_comb begin
    prew = (s0_mode == MODE_PREWITT);
    gx_c = wsum(win[0][0], win[1][0], win[2][0], prew)
         - wsum(win[0][2], win[1][2], win[2][2], prew);
    gy_c = wsum(win[0][0], win[0][1], win[0][2], prew)
         - wsum(win[2][0], win[2][1], win[2][2], prew);
  end

  logic [GW-1:0] ax, ay, mag;
  pix_t          sat, out_c;

  always_comb begin
    ax  = s1_gx[GW-1] ? $unsigned(-s1_gx) : $unsigned(s1_gx);
    ay  = s1_gy[GW-1] ? $unsigned(-s1_gy) : $unsigned(s1_gy);
    mag = ax + ay;
    sat = (|mag[GW-1:DATA_W]) ? '1 : mag[DATA_W-1:0];
    case (s1_mode)
      MODE_THRESH: out_c = (mag >= GW'(s1_thresh)) ? '1 : '0;
      MODE_PASS:   out_c = s1_center;
      default:     out_c = sat;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      width_q   <= CW'(3);
      mode_q    <= MODE_SOBEL;
      thresh_q  <= '0;
      started   <= 1'b0;
      sof_pend  <= 1'b0;
      s0_valid  <= 1'b0;
      s0_sof    <= 1'b0;
      s0_eol    <= 1'b0;
      s0_mode   <= MODE_SOBEL;
      s0_thresh <= '0;
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eol    <= 1'b0;
      s1_mode   <= MODE_SOBEL;
      s1_thresh <= '0;
      s1_center <= '0;
      s1_gx     <= '0;
      s1_gy     <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_sof     <= 1'b0;
      m_eol     <= 1'b0;
    end else if (en) begin
      if (accept) begin
        width_q  <= width_eff;
        mode_q   <= mode_eff;
        thresh_q <= thresh_eff;
        if (last_col) begin
          col <= '0;
          row <= (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
        end else begin
          col <= col_eff + CW'(1);
          row <= row_eff;
        end
        if (s_sof) begin
          started  <= 1'b1;
          sof_pend <= 1'b1;
        end else if (produce) begin
          sof_pend <= 1'b0;
        end
      end

      s0_valid <= accept && produce;
      if (accept && produce) begin
        s0_sof    <= sof_pend;
        s0_eol    <= last_col;
        s0_mode   <= mode_eff;
        s0_thresh <= thresh_eff;
      end

      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_sof    <= s0_sof;
        s1_eol    <= s0_eol;
        s1_mode   <= s0_mode;
        s1_thresh <= s0_thresh;
        s1_center <= win[1][1];
        s1_gx     <= gx_c;
        s1_gy     <= gy_c;
      end

      m_valid <= s1_valid;
      if (s1_valid) begin
        m_data <= out_c;
        m_sof  <= s1_sof;
        m_eol  <= s1_eol;
      end
    end
  end

endmodule

// File: tb/tb_edge_filter_3x3.sv
// Randomized bench for edge_filter_3x3: frames are modelled as whole 2D images and
// every expected output pixel is derived directly from the filter definitions.
module tb_edge_filter_3x3;

  localparam int DW = 8;
  localparam int MW = 16;
  localparam int CW = $clog2(MW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_sof;
  logic [DW-1:0] s_data;
  logic [CW-1:0] cfg_width;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_thresh;
  logic          m_valid, m_ready, m_sof, m_eol;
  logic [DW-1:0] m_data;

  edge_filter_3x3 #(.DATA_W(DW), .MAX_W(MW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .cfg_width(cfg_width), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit sof;
    bit eol;
  } exp_t;

  exp_t expq[$];
  int   img[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc19_cyc = 0;
  int   first_out_cyc = -1;
  bit   bp = 0, gaps = 0, stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs straight from the image: one per pixel at row>=2,col>=2
  task automatic model_frame(input int w, input int n, input int mode, input int thresh);
    int wt[3];
    int r, c, gx, gy, mag, v;
    bit first;
    first = 1;
    wt[0] = 1; wt[1] = (mode == 1) ? 1 : 2; wt[2] = 1;
    for (int i = 0; i < n; i++) begin
      r = i / w;
      c = i % w;
      if (r >= 2 && c >= 2) begin
        gx = 0;
        gy = 0;
        for (int k = 0; k < 3; k++) begin
          gx += wt[k] * (img[(r-2+k)*w + c-2] - img[(r-2+k)*w + c]);
          gy += wt[k] * (img[(r-2)*w + c-2+k] - img[r*w + c-2+k]);
        end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        case (mode)
          0, 1:    v = (mag > 255) ? 255 : mag;
          2:       v = (mag >= thresh) ? 255 : 0;
          default: v = img[(r-1)*w + c-1];
        endcase
        expq.push_back('{v, first, (c == w-1)});
        first = 0;
      end
    end
  endtask

  // kind: 0 random, 1 constant 100, 2 vertical edge at column 4
  task automatic send_frame(input int wcfg, input int h, input int mode, input int thresh,
                            input int kind, input int nmax, input bit sof_on);
    int w, n, guard;
    bit acc;
    w = (wcfg < 3) ? 3 : ((wcfg > MW) ? MW : wcfg);
    img.delete();
    for (int i = 0; i < w*h; i++) begin
      case (kind)
        1:       img.push_back(100);
        2:       img.push_back(((i % w) < 4) ? 0 : 255);
        default: img.push_back(int'($urandom_range(255)));
      endcase
    end
    n = (nmax > 0 && nmax < w*h) ? nmax : w*h;
    if (sof_on) model_frame(w, n, mode, thresh);
    for (int i = 0; i < n; i++) begin
      guard = 0;
      do begin
        if (gaps && $urandom_range(3) == 0) begin
          s_valid = 1'b0;
          s_data  = DW'($urandom_range(255));
          s_sof   = 1'b0;
        end else begin
          s_valid = 1'b1;
          s_data  = DW'(img[i]);
          s_sof   = sof_on && (i == 0);
        end
        if (i == 0) begin
          cfg_width  = CW'(wcfg);
          cfg_mode   = 2'(mode);
          cfg_thresh = DW'(thresh);
        end else begin
          cfg_width  = CW'($urandom_range(MW));
          cfg_mode   = 2'($urandom_range(3));
          cfg_thresh = DW'($urandom_range(255));
        end
        m_ready = stall ? 1'b0 : (bp ? 1'($urandom_range(1)) : 1'b1);
        #1;
        acc = s_valid && s_ready;
        @(posedge clk); #1;
        guard++;
        if (acc && i == 18) acc19_cyc = cyc;
      end while (!acc && guard < 200);
      if (!acc) begin
        check("accept_timeout", acc, 1);
        break;
      end
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    s_valid = 1'b0;
    while ((expq.size() != 0 || m_valid) && guard < 1000) begin
      m_ready = bp ? 1'($urandom_range(1)) : 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    check("drain_empty", expq.size(), 0);
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Output monitor: stability under stall and in-order comparison against the model
  initial begin
    exp_t e;
    bit hold_v;
    logic [DW-1:0] hold_d;
    logic [1:0] hold_f;
    hold_v = 0;
    hold_d = '0;
    hold_f = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 0;
      end else begin
        if (hold_v) begin
          check("hold_valid", m_valid, 1);
          check("hold_data", m_data, hold_d);
          check("hold_flags", {m_sof, m_eol}, hold_f);
        end
        hold_v = m_valid && !m_ready;
        hold_d = m_data;
        hold_f = {m_sof, m_eol};
        if (m_valid && first_out_cyc < 0) first_out_cyc = cyc;
        if (m_valid && m_ready) begin
          if (expq.size() == 0) begin
            check("extra_output", expq.size(), 1);
          end else begin
            e = expq.pop_front();
            check("data", m_data, e.data);
            check("sof", m_sof, e.sof);
            check("eol", m_eol, e.eol);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
    cfg_width = '0; cfg_mode = '0; cfg_thresh = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_sof", m_sof, 0);
    check("rst_m_eol", m_eol, 0);
    check("rst_s_ready", s_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // pixels before any start-of-frame are swallowed
    send_frame(8, 3, 0, 0, 0, 0, 0);
    drain();

    // constant image: all-zero gradient, 12 outputs
    send_frame(8, 4, 0, 0, 1, 0, 1);
    drain();

    // vertical edge, Sobel, with latency from the 19th pixel
    first_out_cyc = -1;
    send_frame(8, 4, 0, 0, 2, 0, 1);
    drain();
    check("edge_latency", first_out_cyc - acc19_cyc, 2);

    // Prewitt and thresholded Sobel on the same edge, then on random content
    send_frame(8, 4, 1, 0, 2, 0, 1);
    send_frame(8, 4, 2, 200, 2, 0, 1);
    send_frame(9, 5, 2, 200, 0, 0, 1);
    drain();

    // passthrough under random backpressure and input gaps
    bp = 1; gaps = 1;
    send_frame(10, 6, 3, 0, 0, 0, 1);
    drain();

    // frame restarted at row 1 col 3 with a narrower width
    bp = 0; gaps = 0;
    send_frame(8, 4, 3, 0, 0, 11, 1);
    send_frame(5, 4, 3, 0, 0, 0, 1);
    drain();
    send_frame(8, 4, 0, 0, 0, 11, 1);
    send_frame(5, 4, 0, 0, 0, 0, 1);
    drain();

    // back-to-back random frames, including widths that clamp to 3
    bp = 1; gaps = 1;
    send_frame(2, 4, 0, 0, 0, 0, 1);
    for (int f = 0; f < 6; f++)
      send_frame($urandom_range(2, 12), $urandom_range(3, 6), $urandom_range(3),
                 $urandom_range(255), 0, 0, 1);
    drain();

    // reset while output is stalled
    bp = 0; gaps = 0; stall = 1;
    send_frame(8, 4, 3, 0, 0, 20, 1);
    repeat (3) @(posedge clk);
    #1;
    check("stall_m_valid", m_valid, 1);
    check("stall_s_ready", s_ready, 0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 1);
    expq.delete();
    @(negedge clk); #2;
    rst = 1'b0;
    stall = 0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("postrst_m_valid", m_valid, 0);
    send_frame(8, 3, 0, 0, 0, 0, 0);
    drain();
    send_frame(6, 4, 0, 0, 0, 0, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
